// File: rtl/best_state_select.sv
// Pipelined minimum path-metric search: a registered binary comparator tree with valid/ready flow.
// Define METRIC_NORM_EN to add the norm_metrics output (each metric minus the minimum).
module best_state_select #(
  parameter int NUM_STATES = 8,
  parameter int METRIC_W   = 4,
  localparam int STATE_W   = $clog2(NUM_STATES)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [NUM_STATES*METRIC_W-1:0]   in_metrics,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [STATE_W-1:0]               bstate,
`ifdef METRIC_NORM_EN
  output logic [METRIC_W-1:0]              min_metric,
  output logic [NUM_STATES*METRIC_W-1:0]   norm_metrics
`else
  output logic [METRIC_W-1:0]              min_metric
`endif
);

  localparam int LEVELS = $clog2(NUM_STATES);

  // Tree nodes use heap numbering: node n has children 2n (lower states) and 2n+1.
  // Leaves NUM_STATES..2*NUM_STATES-1 are the input lanes; node 1 is the output stage.
  logic [METRIC_W-1:0] tree_met [1:NUM_STATES-1];
  logic [STATE_W-1:0]  tree_idx [1:NUM_STATES-1];
  logic [METRIC_W-1:0] all_met  [2:2*NUM_STATES-1];
  logic [STATE_W-1:0]  all_idx  [2:2*NUM_STATES-1];
  logic [METRIC_W-1:0] win_met  [1:NUM_STATES-1];
  logic [STATE_W-1:0]  win_idx  [1:NUM_STATES-1];
  logic [LEVELS-1:0]   stage_vld;
  logic [LEVELS-1:0]   vld_chain;
  logic                adv;

  assign adv       = !out_valid || out_ready;
  assign in_ready  = adv;
  assign out_valid = stage_vld[LEVELS-1];
  assign vld_chain = LEVELS'({stage_vld, in_valid});
  assign bstate    = tree_idx[1];
  assign min_metric = tree_met[1];

  always_comb begin
    for (int n = 2; n < NUM_STATES; n++) begin
      all_met[n] = tree_met[n];
      all_idx[n] = tree_idx[n];
    end
    for (int k = 0; k < NUM_STATES; k++) begin
      all_met[NUM_STATES+k] = in_metrics[k*METRIC_W +: METRIC_W];
      all_idx[NUM_STATES+k] = STATE_W'(k);
    end
  end

  // The lower-index child wins on equal metrics, giving the lowest index among tied minima.
  always_comb begin
    for (int n = 1; n < NUM_STATES; n++) begin
      if (all_met[2*n] <= all_met[2*n+1]) begin
        win_met[n] = all_met[2*n];
        win_idx[n] = all_idx[2*n];
      end else begin
        win_met[n] = all_met[2*n+1];
        win_idx[n] = all_idx[2*n+1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_vld <= '0;
      for (int n = 1; n < NUM_STATES; n++) begin
        tree_met[n] <= '0;
        tree_idx[n] <= '0;
      end
    end else if (adv) begin
      stage_vld <= vld_chain;
      for (int n = 2; n < NUM_STATES; n++) begin
        tree_met[n] <= win_met[n];
        tree_idx[n] <= win_idx[n];
      end
      if (vld_chain[LEVELS-1]) begin
        tree_met[1] <= win_met[1];
        tree_idx[1] <= win_idx[1];
      end
    end
  end

`ifdef METRIC_NORM_EN
  // Slot s holds the metric vector belonging to tree stage s+1; the last slot pairs with bstate.
  logic [NUM_STATES*METRIC_W-1:0] vec_sr  [0:LEVELS-1];
  logic [NUM_STATES*METRIC_W-1:0] vec_src [0:LEVELS-1];

  always_comb begin
    vec_src[0] = in_metrics;
    for (int s = 1; s < LEVELS; s++) begin
      vec_src[s] = vec_sr[s-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < LEVELS; s++) begin
        vec_sr[s] <= '0;
      end
    end else if (adv) begin
      for (int s = 0; s < LEVELS - 1; s++) begin
        vec_sr[s] <= vec_src[s];
      end
      if (vld_chain[LEVELS-1]) begin
        vec_sr[LEVELS-1] <= vec_src[LEVELS-1];
      end
    end
  end

  always_comb begin
    norm_metrics = '0;
    for (int k = 0; k < NUM_STATES; k++) begin
      norm_metrics[k*METRIC_W +: METRIC_W] = vec_sr[LEVELS-1][k*METRIC_W +: METRIC_W] - tree_met[1];
    end
  end
`else
`endif

endmodule
